aes_stream_arbiter: RTL and testbench

//  Packet-granular round-robin arbiter that shares the single AES encryptor stream input between two
//  128-bit AXI-Stream sources (port 0: image reader, port 1: auxiliary/test-vector source).

---
 rtl/aes_stream_pkg.sv | 27 ++
 rtl/axis_reg_slice.sv | 32 +++
 rtl/aes_stream_arbiter.sv | 140 ++++++++++++++
 tb/tb_aes_stream_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_stream_pkg.sv
// Shared types and constants for the AES input stream arbiter: AXI-Stream widths,
// arbiter state encoding and source identifiers.
package aes_stream_pkg;

  localparam int AXIS_DATA_W = 128;
  localparam int AXIS_KEEP_W = 16;
  localparam int SRC_ID_W    = 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  typedef logic [SRC_ID_W-1:0] src_id_t;

  localparam src_id_t SRC_IMG = 1'b0;
  localparam src_id_t SRC_AUX = 1'b1;

  // One output beat as held by the output register.
  typedef struct packed {
    logic [AXIS_DATA_W-1:0] data;
    logic [AXIS_KEEP_W-1:0] keep;
    logic                   last;
    src_id_t                id;
  } axis_beat_t;

endpackage

// File: rtl/axis_reg_slice.sv
// Single-entry output register for the arbitrated stream; reports when it can take
// a new beat in the same cycle (empty, or current beat leaving).
module axis_reg_slice
  import aes_stream_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  axis_beat_t load_beat,
  output logic       free,
  output logic       valid,
  output axis_beat_t beat,
  input  logic       ready
);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      beat  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      beat  <= load_beat;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

  assign free = !valid || ready;

endmodule

// File: rtl/aes_stream_arbiter.sv
// Packet-granular round-robin arbiter feeding the AES encryptor from two 128-bit
// AXI-Stream sources, with per-source packet counters and an overrun watchdog.
module aes_stream_arbiter
  import aes_stream_pkg::*;
#(
  parameter int MAX_BEATS = 768,
  parameter int BEAT_W    = 10,
  parameter int CNT_W     = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,

  input  logic [AXIS_DATA_W-1:0] s0_axis_tdata,
  input  logic [AXIS_KEEP_W-1:0] s0_axis_tkeep,
  input  logic                   s0_axis_tlast,
  input  logic                   s0_axis_tvalid,
  output logic                   s0_axis_tready,

  input  logic [AXIS_DATA_W-1:0] s1_axis_tdata,
  input  logic [AXIS_KEEP_W-1:0] s1_axis_tkeep,
  input  logic                   s1_axis_tlast,
  input  logic                   s1_axis_tvalid,
  output logic                   s1_axis_tready,

  output logic [AXIS_DATA_W-1:0] m_axis_tdata,
  output logic [AXIS_KEEP_W-1:0] m_axis_tkeep,
  output logic                   m_axis_tlast,
  output logic [SRC_ID_W-1:0]    m_axis_tid,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,

  output logic                   busy,
  output logic [CNT_W-1:0]       pkt_cnt0,
  output logic [CNT_W-1:0]       pkt_cnt1,
  output logic                   err_overrun
);

  arb_state_e        state, state_nxt;
  src_id_t           grant, grant_nxt;
  src_id_t           rr_last, rr_last_nxt;
  logic [BEAT_W-1:0] beat_cnt;

  logic       out_free;
  logic       out_valid;
  axis_beat_t out_beat;
  axis_beat_t in_beat;

  logic sel_valid;
  logic sel_last;
  logic accept;
  logic beat_limit;
  logic pkt_end;
  logic forced_end;

  // NOTE: every signal driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_nxt   = state;
    grant_nxt   = grant;
    rr_last_nxt = rr_last;

    sel_valid  = (grant == SRC_AUX) ? s1_axis_tvalid : s0_axis_tvalid;
    sel_last   = (grant == SRC_AUX) ? s1_axis_tlast  : s0_axis_tlast;
    accept     = (state == ST_GRANT) && sel_valid && out_free;
    // The beat that would bring the packet to MAX_BEATS closes it regardless of tlast.
    beat_limit = (beat_cnt == BEAT_W'(MAX_BEATS - 1));
    pkt_end    = accept && (sel_last || beat_limit);
    forced_end = accept && !sel_last && beat_limit;

    in_beat.data = (grant == SRC_AUX) ? s1_axis_tdata : s0_axis_tdata;
    in_beat.keep = (grant == SRC_AUX) ? s1_axis_tkeep : s0_axis_tkeep;
    in_beat.last = sel_last || beat_limit;
    in_beat.id   = grant;

    unique case (state)
      ST_IDLE: begin
        if (enable && (s0_axis_tvalid || s1_axis_tvalid)) begin
          state_nxt = ST_GRANT;
          if (s0_axis_tvalid && !s1_axis_tvalid)      grant_nxt = SRC_IMG;
          else if (s1_axis_tvalid && !s0_axis_tvalid) grant_nxt = SRC_AUX;
          else                                        grant_nxt = ~rr_last;
        end
      end
      ST_GRANT: begin
        if (pkt_end) begin
          state_nxt   = ST_IDLE;
          rr_last_nxt = grant;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      grant       <= SRC_IMG;
      rr_last     <= SRC_AUX;
      beat_cnt    <= '0;
      pkt_cnt0    <= '0;
      pkt_cnt1    <= '0;
      err_overrun <= 1'b0;
    end else begin
      state   <= state_nxt;
      grant   <= grant_nxt;
      rr_last <= rr_last_nxt;

      if (state == ST_IDLE)  beat_cnt <= '0;
      else if (accept)       beat_cnt <= beat_cnt + BEAT_W'(1);

      if (pkt_end && grant == SRC_IMG) pkt_cnt0 <= pkt_cnt0 + CNT_W'(1);
      if (pkt_end && grant == SRC_AUX) pkt_cnt1 <= pkt_cnt1 + CNT_W'(1);

      if (forced_end) err_overrun <= 1'b1;
    end
  end

  assign s0_axis_tready = (state == ST_GRANT) && (grant == SRC_IMG) && out_free;
  assign s1_axis_tready = (state == ST_GRANT) && (grant == SRC_AUX) && out_free;
  assign busy           = (state == ST_GRANT);

  axis_reg_slice u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .load_beat (in_beat),
    .free      (out_free),
    .valid     (out_valid),
    .beat      (out_beat),
    .ready     (m_axis_tready)
  );

  assign m_axis_tvalid = out_valid;
  assign m_axis_tdata  = out_beat.data;
  assign m_axis_tkeep  = out_beat.keep;
  assign m_axis_tlast  = out_beat.last;
  assign m_axis_tid    = out_beat.id;

endmodule

// File: tb/tb_aes_stream_arbiter.sv
// Randomized self-checking bench for aes_stream_arbiter: per-source scoreboards built
// from the packet/overrun rules plus directed ordering, stall, enable and reset cases.
module tb_aes_stream_arbiter;
  import aes_stream_pkg::*;

  localparam int MAX_BEATS = 4;
  localparam int BEAT_W    = 10;
  localparam int CNT_W     = 2;

  typedef struct {
    logic [127:0] data;
    logic [15:0]  keep;
    logic         last;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable;
  logic [127:0] s0_axis_tdata, s1_axis_tdata, m_axis_tdata;
  logic [15:0]  s0_axis_tkeep, s1_axis_tkeep, m_axis_tkeep;
  logic         s0_axis_tlast, s1_axis_tlast, m_axis_tlast;
  logic         s0_axis_tvalid, s1_axis_tvalid, m_axis_tvalid;
  logic         s0_axis_tready, s1_axis_tready, m_axis_tready;
  logic [0:0]   m_axis_tid;
  logic         busy;
  logic [CNT_W-1:0] pkt_cnt0, pkt_cnt1;
  logic         err_overrun;

  always #5 clk = ~clk;

  aes_stream_arbiter #(
    .MAX_BEATS (MAX_BEATS),
    .BEAT_W    (BEAT_W),
    .CNT_W     (CNT_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .s0_axis_tdata  (s0_axis_tdata),
    .s0_axis_tkeep  (s0_axis_tkeep),
    .s0_axis_tlast  (s0_axis_tlast),
    .s0_axis_tvalid (s0_axis_tvalid),
    .s0_axis_tready (s0_axis_tready),
    .s1_axis_tdata  (s1_axis_tdata),
    .s1_axis_tkeep  (s1_axis_tkeep),
    .s1_axis_tlast  (s1_axis_tlast),
    .s1_axis_tvalid (s1_axis_tvalid),
    .s1_axis_tready (s1_axis_tready),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tkeep   (m_axis_tkeep),
    .m_axis_tlast   (m_axis_tlast),
    .m_axis_tid     (m_axis_tid),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (m_axis_tready),
    .busy           (busy),
    .pkt_cnt0       (pkt_cnt0),
    .pkt_cnt1       (pkt_cnt1),
    .err_overrun    (err_overrun)
  );

  int n_checks = 0;
  int n_fail   = 0;

  beat_t src_q0[$], src_q1[$], exp_q0[$], exp_q1[$];
  int    run_len[2];
  int    pkt_model[2];
  int    pops[2];
  logic  err_model;
  int    vpct, rpct;
  int    cyc, last_end;
  int    order_q[$], gap_q[$];
  logic  in_pkt, cur_tid;
  logic  prev_stall, prev_last, prev_tid;
  logic [127:0] prev_data;
  logic [15:0]  prev_keep;
  int    stall_cnt, excl_viol, s1_ready_seen, out_beats;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic make_pkt(input int src, input int len, input bit with_last);
    for (int i = 0; i < len; i++) begin
      beat_t b;
      b.data = {$urandom, $urandom, $urandom, $urandom};
      b.keep = 16'($urandom);
      b.last = with_last && (i == len - 1);
      if (src == 0) src_q0.push_back(b);
      else          src_q1.push_back(b);
    end
  endtask

  task automatic drive();
    s0_axis_tvalid = (src_q0.size() > 0) && (int'($urandom_range(99)) < vpct);
    s1_axis_tvalid = (src_q1.size() > 0) && (int'($urandom_range(99)) < vpct);
    if (src_q0.size() > 0) begin
      s0_axis_tdata = src_q0[0].data; s0_axis_tkeep = src_q0[0].keep; s0_axis_tlast = src_q0[0].last;
    end else begin
      s0_axis_tdata = {$urandom, $urandom, $urandom, $urandom}; s0_axis_tkeep = 16'($urandom); s0_axis_tlast = 1'($urandom);
    end
    if (src_q1.size() > 0) begin
      s1_axis_tdata = src_q1[0].data; s1_axis_tkeep = src_q1[0].keep; s1_axis_tlast = src_q1[0].last;
    end else begin
      s1_axis_tdata = {$urandom, $urandom, $urandom, $urandom}; s1_axis_tkeep = 16'($urandom); s1_axis_tlast = 1'($urandom);
    end
    m_axis_tready = int'($urandom_range(99)) < rpct;
  endtask

  // A source beat becomes an output beat; it closes its packet on real tlast or as the MAX_BEATS-th beat.
  task automatic pop_src(input int src);
    beat_t b;
    if (src == 0) b = src_q0.pop_front();
    else          b = src_q1.pop_front();
    pops[src]++;
    run_len[src]++;
    if (run_len[src] == MAX_BEATS && !b.last) err_model = 1'b1;
    if (b.last || run_len[src] == MAX_BEATS) begin
      b.last         = 1'b1;
      run_len[src]   = 0;
      pkt_model[src] = (pkt_model[src] + 1) % (1 << CNT_W);
    end
    if (src == 0) exp_q0.push_back(b);
    else          exp_q1.push_back(b);
  endtask

  task automatic monitor();
    beat_t e;
    logic  t;
    logic  ok;
    if (s0_axis_tready && s1_axis_tready) excl_viol++;
    if (s1_axis_tready) s1_ready_seen++;
    if (prev_stall) begin
      stall_cnt++;
      check("hold_ctl", 128'({m_axis_tvalid, m_axis_tid, m_axis_tlast, m_axis_tkeep}),
            128'({1'b1, prev_tid, prev_last, prev_keep}));
      check("hold_data", m_axis_tdata, prev_data);
    end
    prev_stall = m_axis_tvalid && !m_axis_tready;
    prev_data  = m_axis_tdata;
    prev_keep  = m_axis_tkeep;
    prev_last  = m_axis_tlast;
    prev_tid   = m_axis_tid;
    if (m_axis_tvalid && m_axis_tready) begin
      out_beats++;
      t  = m_axis_tid;
      ok = t ? (exp_q1.size() > 0) : (exp_q0.size() > 0);
      check("exp_avail", 128'(ok), 128'(1));
      if (ok) begin
        e = t ? exp_q1.pop_front() : exp_q0.pop_front();
        check("beat_data", m_axis_tdata, e.data);
        check("beat_ctl", 128'({m_axis_tkeep, m_axis_tlast}), 128'({e.keep, e.last}));
      end
      if (in_pkt) check("tid_contig", 128'(t), 128'(cur_tid));
      else begin
        order_q.push_back(int'(t));
        gap_q.push_back(cyc - last_end);
      end
      cur_tid = t;
      in_pkt  = !m_axis_tlast;
      if (m_axis_tlast) last_end = cyc;
    end
  endtask

  // Sample on the falling edge, apply handshake results and new stimulus just after the rising edge.
  task automatic step();
    logic f0, f1, in_rst;
    @(negedge clk);
    cyc++;
    in_rst = rst;
    f0 = s0_axis_tvalid && s0_axis_tready;
    f1 = s1_axis_tvalid && s1_axis_tready;
    if (!in_rst) monitor();
    @(posedge clk);
    #1;
    if (!in_rst) begin
      if (f0) pop_src(0);
      if (f1) pop_src(1);
    end
    drive();
  endtask

  task automatic clear_model();
    src_q0.delete(); src_q1.delete(); exp_q0.delete(); exp_q1.delete();
    run_len   = '{0, 0};
    pkt_model = '{0, 0};
    err_model  = 1'b0;
    in_pkt     = 1'b0;
    prev_stall = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_model();
    drive();
    step();
    step();
    rst = 1'b0;
  endtask

  function automatic bit pending();
    return (src_q0.size() > 0) || (src_q1.size() > 0) || (exp_q0.size() > 0) ||
           (exp_q1.size() > 0) || m_axis_tvalid || busy;
  endfunction

  task automatic wait_idle(input int limit, input string tag);
    int n = 0;
    while (pending() && n < limit) begin
      step();
      n++;
    end
    check(tag, 128'(pending()), 128'(0));
  endtask

  initial begin
    int p, n, busy_seen;
    rst = 1'b1; enable = 1'b1; vpct = 100; rpct = 100;
    cyc = 0; last_end = 0; pops = '{0, 0};
    stall_cnt = 0; excl_viol = 0; s1_ready_seen = 0; out_beats = 0; cur_tid = 1'b0;
    do_reset();

    check("rst_tvalid", 128'(m_axis_tvalid), 128'(0));
    check("rst_tdata",  m_axis_tdata, 128'(0));
    check("rst_ctl",    128'({m_axis_tkeep, m_axis_tlast, m_axis_tid}), 128'(0));
    check("rst_busy",   128'(busy), 128'(0));
    check("rst_cnt",    128'({pkt_cnt0, pkt_cnt1, err_overrun}), 128'(0));

    // Single source, 4-beat packet
    make_pkt(0, 4, 1'b1);
    order_q.delete(); gap_q.delete(); s1_ready_seen = 0; out_beats = 0;
    drive();
    wait_idle(30, "t1_done");
    check("t1_beats", 128'(out_beats), 128'(4));
    check("t1_npkt", 128'(order_q.size()), 128'(1));
    check("t1_tid", 128'(order_q[0]), 128'(0));
    check("t1_cnt0", 128'(pkt_cnt0), 128'(1));
    check("t1_s1_ready", 128'(s1_ready_seen), 128'(0));

    // Tie from reset: alternation 0,1,0,1 with one idle bubble between packets
    do_reset();
    make_pkt(0, 3, 1'b1); make_pkt(0, 3, 1'b1);
    make_pkt(1, 2, 1'b1); make_pkt(1, 2, 1'b1);
    order_q.delete(); gap_q.delete();
    drive();
    wait_idle(80, "t2_done");
    check("t2_npkt", 128'(order_q.size()), 128'(4));
    for (int i = 0; i < 4; i++) check($sformatf("t2_order%0d", i), 128'(order_q[i]), 128'(i % 2));
    for (int i = 1; i < 4; i++) check($sformatf("t2_gap%0d", i), 128'(gap_q[i]), 128'(2));
    check("t2_cnt", 128'({pkt_cnt0, pkt_cnt1}), 128'({2'd2, 2'd2}));

    // Output backpressure mid-packet
    make_pkt(0, 4, 1'b1);
    stall_cnt = 0;
    drive();
    for (int i = 0; i < 8; i++) begin
      rpct = (i == 2 || i == 3) ? 0 : 100;
      step();
    end
    rpct = 100;
    wait_idle(30, "t3_done");
    check("t3_stalled", 128'(stall_cnt > 0), 128'(1));
    check("t3_cnt0", 128'(pkt_cnt0), 128'(pkt_model[0]));

    // Enable dropped mid-packet
    make_pkt(0, 4, 1'b1);
    drive();
    p = pops[0]; n = 0;
    while (pops[0] < p + 2 && n < 20) begin step(); n++; end
    enable = 1'b0;
    make_pkt(1, 2, 1'b1);
    drive();
    for (int i = 0; i < 8; i++) step();
    busy_seen = 0;
    for (int i = 0; i < 4; i++) begin step(); if (busy) busy_seen++; end
    check("t5_busy_off", 128'(busy_seen), 128'(0));
    check("t5_s1_held", 128'(src_q1.size()), 128'(2));
    check("t5_cnt0", 128'(pkt_cnt0), 128'(pkt_model[0]));
    enable = 1'b1;
    step();
    check("t5_grant", 128'(busy), 128'(1));
    wait_idle(30, "t5_done");

    // Overrun: 6 beats without tlast on source 1
    check("t4_err_pre", 128'(err_overrun), 128'(0));
    make_pkt(1, 6, 1'b0);
    order_q.delete(); gap_q.delete();
    drive();
    n = 0;
    while (src_q1.size() > 0 && n < 40) begin step(); n++; end
    for (int i = 0; i < 4; i++) step();
    check("t4_err", 128'(err_overrun), 128'(1));
    check("t4_cnt1", 128'(pkt_cnt1), 128'(pkt_model[1]));
    check("t4_npkt", 128'(order_q.size()), 128'(2));
    check("t4_tid2", 128'(order_q[1]), 128'(1));
    check("t4_gap", 128'(gap_q[1]), 128'(2));
    check("t4_hold", 128'(busy), 128'(1));
    make_pkt(1, 1, 1'b1);
    drive();
    wait_idle(30, "t4_done");
    check("t4_cnt1_end", 128'(pkt_cnt1), 128'(pkt_model[1]));

    // Reset in the middle of a packet
    make_pkt(0, 4, 1'b1);
    drive();
    p = pops[0]; n = 0;
    while (pops[0] < p + 3 && n < 20) begin step(); n++; end
    rst = 1'b1;
    clear_model();
    drive();
    step();
    check("t6_tvalid", 128'(m_axis_tvalid), 128'(0));
    check("t6_busy", 128'(busy), 128'(0));
    check("t6_cnt", 128'({pkt_cnt0, pkt_cnt1, err_overrun}), 128'(0));
    rst = 1'b0;

    // Counter wrap: five packets on a 2-bit counter
    for (int i = 0; i < 5; i++) make_pkt(0, 1 + int'($urandom_range(2)), 1'b1);
    drive();
    wait_idle(80, "t6_wrap_done");
    check("t6_wrap", 128'(pkt_cnt0), 128'(1));

    // Randomized traffic against the scoreboard
    vpct = 70; rpct = 70;
    for (int s = 0; s < 2; s++)
      for (int k = 0; k < 15; k++) make_pkt(s, 1 + int'($urandom_range(5)), 1'b1);
    drive();
    n = 0;
    while (pending() && n < 5000) begin
      enable = ($urandom_range(9) != 0);
      step();
      n++;
    end
    enable = 1'b1;
    check("rand_drained", 128'(pending()), 128'(0));
    check("rand_cnt0", 128'(pkt_cnt0), 128'(pkt_model[0]));
    check("rand_cnt1", 128'(pkt_cnt1), 128'(pkt_model[1]));
    check("rand_err", 128'(err_overrun), 128'(err_model));
    check("tready_excl", 128'(excl_viol), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
